// File: rtl/priv_1_13_plic_lite.sv
// Platform-level external interrupt arbiter: level gateways, priority/threshold
// arbitration and a claim/complete handshake toward the machine external interrupt.
module priv_1_13_plic_lite #(
    parameter int NSRC   = 8,
    parameter int PRIO_W = 3,
    localparam int IDW   = $clog2(NSRC + 1)
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic [NSRC-1:0]   irq_src,
    input  logic              prio_we,
    input  logic [IDW-1:0]    prio_idx,
    input  logic [PRIO_W-1:0] prio_wdata,
    input  logic              en_we,
    input  logic [NSRC-1:0]   en_wdata,
    input  logic              thresh_we,
    input  logic [PRIO_W-1:0] thresh_wdata,
    input  logic              claim_req,
    output logic              claim_ready,
    output logic              claim_valid,
    output logic [IDW-1:0]    claim_id,
    input  logic              complete_req,
    input  logic [IDW-1:0]    complete_id,
    output logic              ext_int_m,
    output logic              clear_ext_int_m,
    output logic [NSRC-1:0]   pending
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CLAIM  = 2'd1,
        ST_SETTLE = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_next_s;
    logic [PRIO_W-1:0] prio_r [NSRC];
    logic [NSRC-1:0]   en_r;
    logic [PRIO_W-1:0] thresh_r;
    logic [NSRC-1:0]   pending_r;
    logic [NSRC-1:0]   inflight_r;
    logic [IDW-1:0]    best_id_r;
    logic [IDW-1:0]    claim_id_r;
    logic              ext_int_m_r;
    logic              clear_ext_int_m_r;

    logic [NSRC-1:0]   elig_s;
    logic [IDW-1:0]    best_id_s;
    logic [PRIO_W-1:0] best_prio_s;
    logic              any_elig_s;
    logic              claim_fire_s;
    logic [NSRC-1:0]   claim_clr_s;
    logic [NSRC-1:0]   complete_clr_s;
    logic [NSRC-1:0]   pending_next_s;
    logic [NSRC-1:0]   inflight_next_s;
    logic              ext_next_s;
    logic              claim_ready_s;
    logic              claim_valid_s;

    // Eligibility and arbitration; strict '>' keeps ties on the lowest ID
    always_comb begin
        elig_s      = {NSRC{1'b0}};
        best_id_s   = {IDW{1'b0}};
        best_prio_s = {PRIO_W{1'b0}};
        for (int i = 0; i < NSRC; i++) begin
            elig_s[i] = pending_r[i] & en_r[i] & (prio_r[i] > thresh_r);
            if (elig_s[i] && (prio_r[i] > best_prio_s)) begin
                best_prio_s = prio_r[i];
                best_id_s   = IDW'(i + 1);
            end else begin
                best_prio_s = best_prio_s;
                best_id_s   = best_id_s;
            end
        end
        any_elig_s = |elig_s;
    end

    // Gateway, claim and completion effects on pending/inflight
    always_comb begin
        claim_fire_s   = (state_r == ST_IDLE) && claim_req;
        claim_clr_s    = {NSRC{1'b0}};
        complete_clr_s = {NSRC{1'b0}};
        for (int i = 0; i < NSRC; i++) begin
            claim_clr_s[i]    = claim_fire_s && (best_id_r == IDW'(i + 1));
            complete_clr_s[i] = complete_req && (complete_id == IDW'(i + 1)) && inflight_r[i];
        end
        // Old inflight gates the gateway, so a completed source re-pends a cycle later
        pending_next_s  = (pending_r | (irq_src & ~inflight_r)) & ~claim_clr_s;
        inflight_next_s = (inflight_r & ~complete_clr_s) | claim_clr_s;
    end

    // Claim FSM next-state
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (claim_req) begin
                    state_next_s = ST_CLAIM;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_CLAIM:  state_next_s = ST_SETTLE;
            ST_SETTLE: state_next_s = ST_IDLE;
            default:   state_next_s = ST_IDLE;
        endcase
        ext_next_s = any_elig_s && (state_next_s == ST_IDLE);
    end

    // Claim FSM outputs
    always_comb begin
        claim_ready_s = 1'b0;
        claim_valid_s = 1'b0;
        case (state_r)
            ST_IDLE:   claim_ready_s = 1'b1;
            ST_CLAIM:  claim_valid_s = 1'b1;
            ST_SETTLE: claim_ready_s = 1'b0;
            default: begin
                claim_ready_s = 1'b0;
                claim_valid_s = 1'b0;
            end
        endcase
    end

    // Claim FSM state register
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Configuration registers: priorities, enable mask, threshold
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < NSRC; i++) begin
                prio_r[i] <= {PRIO_W{1'b0}};
            end
            en_r     <= {NSRC{1'b0}};
            thresh_r <= {PRIO_W{1'b0}};
        end else begin
            for (int i = 0; i < NSRC; i++) begin
                if (prio_we && (prio_idx == IDW'(i + 1))) begin
                    prio_r[i] <= prio_wdata;
                end else begin
                    prio_r[i] <= prio_r[i];
                end
            end
            if (en_we) begin
                en_r <= en_wdata;
            end else begin
                en_r <= en_r;
            end
            if (thresh_we) begin
                thresh_r <= thresh_wdata;
            end else begin
                thresh_r <= thresh_r;
            end
        end
    end

    // Interrupt state and registered outputs
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            pending_r         <= {NSRC{1'b0}};
            inflight_r        <= {NSRC{1'b0}};
            best_id_r         <= {IDW{1'b0}};
            claim_id_r        <= {IDW{1'b0}};
            ext_int_m_r       <= 1'b0;
            clear_ext_int_m_r <= 1'b0;
        end else begin
            pending_r         <= pending_next_s;
            inflight_r        <= inflight_next_s;
            best_id_r         <= best_id_s;
            ext_int_m_r       <= ext_next_s;
            clear_ext_int_m_r <= ext_int_m_r & ~ext_next_s;
            if (claim_fire_s) begin
                claim_id_r <= best_id_r;
            end else begin
                claim_id_r <= claim_id_r;
            end
        end
    end

    assign claim_ready     = claim_ready_s;
    assign claim_valid     = claim_valid_s;
    assign claim_id        = claim_id_r;
    assign ext_int_m       = ext_int_m_r;
    assign clear_ext_int_m = clear_ext_int_m_r;
    assign pending         = pending_r;

endmodule

// File: tb/tb_priv_1_13_plic_lite.sv
// Randomized bench for priv_1_13_plic_lite against a cycle-level behavioural model.
module tb_priv_1_13_plic_lite;

    localparam int NSRC   = 8;
    localparam int PRIO_W = 3;
    localparam int IDW    = 4;

    logic              CLK = 1'b0;
    logic              nRST;
    logic [NSRC-1:0]   irq_src;
    logic              prio_we;
    logic [IDW-1:0]    prio_idx;
    logic [PRIO_W-1:0] prio_wdata;
    logic              en_we;
    logic [NSRC-1:0]   en_wdata;
    logic              thresh_we;
    logic [PRIO_W-1:0] thresh_wdata;
    logic              claim_req;
    logic              claim_ready;
    logic              claim_valid;
    logic [IDW-1:0]    claim_id;
    logic              complete_req;
    logic [IDW-1:0]    complete_id;
    logic              ext_int_m;
    logic              clear_ext_int_m;
    logic [NSRC-1:0]   pending;

    always #5 CLK = ~CLK;

    priv_1_13_plic_lite #(.NSRC(NSRC), .PRIO_W(PRIO_W)) dut (
        .CLK(CLK), .nRST(nRST), .irq_src(irq_src),
        .prio_we(prio_we), .prio_idx(prio_idx), .prio_wdata(prio_wdata),
        .en_we(en_we), .en_wdata(en_wdata),
        .thresh_we(thresh_we), .thresh_wdata(thresh_wdata),
        .claim_req(claim_req), .claim_ready(claim_ready), .claim_valid(claim_valid),
        .claim_id(claim_id), .complete_req(complete_req), .complete_id(complete_id),
        .ext_int_m(ext_int_m), .clear_ext_int_m(clear_ext_int_m), .pending(pending)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural model state
    logic [2:0] m_prio [1:8];
    logic [7:0] m_en, m_pend, m_infl;
    logic [2:0] m_th;
    int         m_phase;   // 0 idle, 1 claim, 2 settle
    int         m_best;    // winner as seen one cycle ago
    logic       m_ext, m_clr;
    int         m_cid;

    function automatic int model_winner();
        for (int p = 7; p >= 1; p--)
            for (int id = 1; id <= 8; id++)
                if (m_pend[id-1] && m_en[id-1] && (int'(m_prio[id]) == p) && (p > int'(m_th)))
                    return id;
        return 0;
    endfunction

    task automatic model_reset();
        for (int id = 1; id <= 8; id++) m_prio[id] = 3'd0;
        m_en = 8'h00; m_pend = 8'h00; m_infl = 8'h00; m_th = 3'd0;
        m_phase = 0; m_best = 0; m_ext = 1'b0; m_clr = 1'b0; m_cid = 0;
    endtask

    task automatic model_update();
        int win, nphase;
        logic fire, next_ext;
        logic [7:0] np, ni;
        win  = model_winner();
        fire = (m_phase == 0) && claim_req;
        np = m_pend; ni = m_infl;
        for (int id = 1; id <= 8; id++) begin
            if (complete_req && (int'(complete_id) == id) && m_infl[id-1]) ni[id-1] = 1'b0;
            if (fire && (m_best == id)) begin
                np[id-1] = 1'b0;
                ni[id-1] = 1'b1;
            end else if (irq_src[id-1] && !m_infl[id-1]) begin
                np[id-1] = 1'b1;
            end
        end
        nphase   = (m_phase == 0) ? (fire ? 1 : 0) : ((m_phase == 1) ? 2 : 0);
        next_ext = (nphase == 0) && (win != 0);
        m_clr    = m_ext && !next_ext;
        m_ext    = next_ext;
        if (fire) m_cid = m_best;
        m_best  = win;
        m_phase = nphase;
        m_pend  = np;
        m_infl  = ni;
        if (prio_we && (int'(prio_idx) >= 1) && (int'(prio_idx) <= 8)) m_prio[int'(prio_idx)] = prio_wdata;
        if (en_we) m_en = en_wdata;
        if (thresh_we) m_th = thresh_wdata;
    endtask

    task automatic compare_all();
        check("pending", pending, m_pend);
        check("ext_int_m", ext_int_m, m_ext);
        check("clear_ext_int_m", clear_ext_int_m, m_clr);
        check("claim_valid", claim_valid, m_phase == 1);
        check("claim_ready", claim_ready, m_phase == 0);
        check("claim_id", claim_id, m_cid);
    endtask

    task automatic step();
        @(posedge CLK);
        model_update();
        @(negedge CLK);
        compare_all();
    endtask

    task automatic idle_inputs();
        irq_src = 8'h00; prio_we = 1'b0; prio_idx = 4'd0; prio_wdata = 3'd0;
        en_we = 1'b0; en_wdata = 8'h00; thresh_we = 1'b0; thresh_wdata = 3'd0;
        claim_req = 1'b0; complete_req = 1'b0; complete_id = 4'd0;
    endtask

    task automatic write_prio(input int id, input int p);
        prio_we = 1'b1; prio_idx = 4'(id); prio_wdata = 3'(p);
        step();
        prio_we = 1'b0;
    endtask

    initial begin
        int cid;
        idle_inputs();
        nRST = 1'b0;
        model_reset();
        repeat (2) @(negedge CLK);
        compare_all();
        nRST = 1'b1;

        // Claim with nothing eligible, then a claim attempt during SETTLE
        claim_req = 1'b1;
        step();
        check("empty_claim_valid", claim_valid, 1'b1);
        check("empty_claim_id", claim_id, 4'd0);
        step();
        check("settle_not_ready", claim_ready, 1'b0);
        step();
        claim_req = 1'b0;
        step();

        // Single source 3 with priority 5 reaches ext_int_m two cycles after the line rises
        prio_we = 1'b1; prio_idx = 4'd3; prio_wdata = 3'd5;
        en_we = 1'b1; en_wdata = 8'hFF; thresh_we = 1'b1; thresh_wdata = 3'd0;
        step();
        idle_inputs();
        irq_src = 8'h04;
        step();
        check("t1_pending3", pending[2], 1'b1);
        check("t1_ext_early", ext_int_m, 1'b0);
        irq_src = 8'h00;
        step();
        check("t1_ext", ext_int_m, 1'b1);

        // Tie between sources 2 and 5 at priority 4 goes to the lower ID
        claim_req = 1'b1;
        step();
        claim_req = 1'b0;
        repeat (3) step();
        write_prio(2, 4);
        write_prio(5, 4);
        irq_src = 8'h12;
        step();
        irq_src = 8'h00;
        repeat (2) step();
        claim_req = 1'b1;
        step();
        claim_req = 1'b0;
        check("t2_claim_id", claim_id, 4'd2);
        repeat (4) step();

        // Completing an ID that is not in flight changes nothing
        complete_req = 1'b1; complete_id = 4'd7;
        step();
        complete_id = 4'd3;
        step();
        complete_req = 1'b0;
        repeat (2) step();

        // Randomized traffic
        for (int cyc = 0; cyc < 3000; cyc++) begin
            irq_src      = 8'($urandom & $urandom);
            prio_we      = ($urandom_range(0, 9) == 0);
            prio_idx     = 4'($urandom_range(0, 15));
            prio_wdata   = 3'($urandom_range(0, 7));
            en_we        = ($urandom_range(0, 29) == 0);
            en_wdata     = 8'($urandom | $urandom);
            thresh_we    = ($urandom_range(0, 19) == 0);
            thresh_wdata = 3'($urandom_range(0, 3));
            claim_req    = ($urandom_range(0, 3) == 0);
            complete_req = ($urandom_range(0, 2) == 0);
            cid = $urandom_range(0, 15);
            if ($urandom_range(0, 1) == 1)
                for (int k = 1; k <= 8; k++)
                    if (m_infl[k-1] && ($urandom_range(0, 2) == 0)) cid = k;
            complete_id = 4'(cid);
            step();
        end

        // Asynchronous reset in the middle of a claim
        idle_inputs();
        irq_src = 8'hFF;
        repeat (3) step();
        claim_req = 1'b1;
        step();
        claim_req = 1'b0;
        check("t6_in_claim", claim_valid, 1'b1);
        #2 nRST = 1'b0;
        #1;
        model_reset();
        check("t6_claim_valid", claim_valid, 1'b0);
        check("t6_pending", pending, 8'h00);
        check("t6_ext", ext_int_m, 1'b0);
        check("t6_ready", claim_ready, 1'b1);
        irq_src = 8'h00;
        @(negedge CLK);
        nRST = 1'b1;
        repeat (3) step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
